// File: rtl/i2c_master.sv
// i2c_master
// Single-master I2C controller. One transaction is START, a 7-bit address
// plus R/W bit, exactly four data bytes (MSB first), then STOP. A write sends
// a 32-bit word to the slave. A read shifts a 32-bit word into rdata.
//
// Ports
//   clk, rst_n   system clock; synchronous active-low reset
//   start        one-cycle request, accepted only when idle
//   rw           0 = write wdata, 1 = read into rdata (sampled with start)
//   addr_sel     0 = SLAVE_ADDR, 1 = addr (sampled with start)
//   addr         alternate 7-bit slave address
//   wdata        32-bit write word, captured on accepted start
//   rdata        last successfully read word
//   busy         high from the cycle after accept until done
//   done         one-cycle pulse at transaction end
//   ack_err      slave NACKed the address or a write byte
//   sda, scl     open-drain bus lines; only ever pulled low or released
module i2c_master #(
    parameter int unsigned CLK_DIV    = 250,
    parameter logic [6:0]  SLAVE_ADDR = 7'b0101010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic        addr_sel,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    inout  wire         sda,
    inout  wire         scl
);

    localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RACK,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        sda_meta_q, sda_meta_d;
    logic        sda_sync_q, sda_sync_d;
    logic        sda_smp_q, sda_smp_d;
    logic        sda_oe_q, sda_oe_d;
    logic        scl_oe_q, scl_oe_d;
    logic [7:0]  addr_byte_q, addr_byte_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_sh_q, rd_sh_d;

    logic tick;
    logic bit_end;
    logic sample;

    always_comb begin
        tick    = (qcnt_q == QMAX);
        bit_end = tick && (phase_q == 2'd3);
        // Sampling at the end of Q2: scl has been high for most of a quarter.
        sample  = tick && (phase_q == 2'd2);
    end

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_err_d   = ack_err_q;
        rdata_d     = rdata_q;
        sda_meta_d  = sda;
        sda_sync_d  = sda_meta_q;
        sda_smp_d   = sda_smp_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        rd_sh_d     = rd_sh_q;

        if (state_q == S_IDLE) begin
            qcnt_d  = '0;
            phase_d = '0;
        end else begin
            qcnt_d = tick ? 16'd0 : qcnt_q + 16'd1;
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end
        end

        if (sample) begin
            sda_smp_d = sda_sync_q;
        end

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    state_d     = S_START;
                    rw_d        = rw;
                    addr_byte_d = {(addr_sel ? addr : SLAVE_ADDR), rw};
                    wdata_d     = wdata;
                    ack_err_d   = 1'b0;
                    busy_d      = 1'b1;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_ADDR;
                    bit_cnt_d = '0;
                end
            end
            S_ADDR: begin
                if (bit_end) begin
                    addr_byte_d = {addr_byte_q[6:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_ADDR_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (bit_end) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    if (sda_smp_q) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        state_d = rw_q ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (bit_end) begin
                    wdata_d   = {wdata_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_WACK;
                    end
                end
            end
            S_WACK: begin
                if (bit_end) begin
                    if (sda_smp_q) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP;
                    end else if (byte_cnt_q == 2'd3) begin
                        state_d = S_STOP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = S_WDATA;
                    end
                end
            end
            S_RDATA: begin
                if (sample) begin
                    rd_sh_d = {rd_sh_q[30:0], sda_sync_q};
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_RACK;
                    end
                end
            end
            S_RACK: begin
                if (bit_end) begin
                    if (byte_cnt_q == 2'd3) begin
                        rdata_d = rd_sh_q;
                        state_d = S_STOP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = S_RDATA;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line drive is decoded from the current state and registered, so the
    // bus lags the phase counter by one clock but never glitches.
    always_comb begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (state_q)
            S_START: begin
                sda_oe_d = phase_q[1];
                scl_oe_d = (phase_q == 2'd3);
            end
            S_ADDR: begin
                scl_oe_d = ~phase_q[1];
                sda_oe_d = ~addr_byte_q[7];
            end
            S_WDATA: begin
                scl_oe_d = ~phase_q[1];
                sda_oe_d = ~wdata_q[31];
            end
            S_ADDR_ACK, S_WACK, S_RDATA: begin
                scl_oe_d = ~phase_q[1];
            end
            S_RACK: begin
                // ACK bytes 1-3, NACK the last byte to end the read.
                scl_oe_d = ~phase_q[1];
                sda_oe_d = (byte_cnt_q != 2'd3);
            end
            S_STOP: begin
                scl_oe_d = ~phase_q[1];
                sda_oe_d = (phase_q != 2'd3);
            end
            default: begin
                sda_oe_d = 1'b0;
                scl_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            rdata_q    <= '0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_smp_q  <= 1'b1;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            rdata_q    <= rdata_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_smp_q  <= sda_smp_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

    // Shift registers carry only data; control decides when they matter.
    always_ff @(posedge clk) begin
        addr_byte_q <= addr_byte_d;
        wdata_q     <= wdata_d;
        rd_sh_q     <= rd_sh_d;
    end

    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_oe_q ? 1'b0 : 1'bz;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master.sv
// Testbench for i2c_master: directed transactions against a cycle-sampled
// slave model that logs every byte seen on the bus.
module tb_i2c_master;

    localparam int          CLK_DIV  = 4;
    localparam int          FULL_CYC = 188 * CLK_DIV;
    localparam int          NACK_CYC = 44 * CLK_DIV;
    localparam int          WN2_CYC  = 29 * 4 * CLK_DIV;
    localparam int          MAX_WAIT = 4000;
    localparam logic [6:0]  SLV_ADDR = 7'b0101010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic        addr_sel = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        ack_err;
    wire         sda_w;
    wire         scl_w;

    pullup (sda_w);
    pullup (scl_w);

    logic slv_low = 1'b0;
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(SLV_ADDR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rw       (rw),
        .addr_sel (addr_sel),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .sda      (sda_w),
        .scl      (scl_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- slave model ----------------
    int          nack_at = 99;
    logic [31:0] rd_word = '0;
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    logic        active = 1'b0;
    int          bitn = 0;
    int          nb = 0;
    int          nmack = 0;
    logic [7:0]  rx = '0;
    logic        is_rd = 1'b0;
    logic        matched = 1'b0;
    logic        last_mack = 1'b1;
    logic [31:0] rd_sh = '0;
    logic [7:0]  log_b [0:7];
    logic        mack [0:3];
    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          start_cyc = 0;

    always @(posedge clk) begin
        scl_prev <= scl_w;
        sda_prev <= sda_w;
        if (!rst_n) begin
            active  <= 1'b0;
            slv_low <= 1'b0;
            bitn    <= 0;
        end else if (scl_w && scl_prev && sda_prev && !sda_w) begin
            active    <= 1'b1;
            bitn      <= 0;
            nb        <= 0;
            nmack     <= 0;
            slv_low   <= 1'b0;
            is_rd     <= 1'b0;
            matched   <= 1'b0;
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end else if (scl_w && scl_prev && !sda_prev && sda_w) begin
            active   <= 1'b0;
            slv_low  <= 1'b0;
            stop_cnt <= stop_cnt + 1;
        end else if (active && scl_w && !scl_prev) begin
            if (bitn < 8) begin
                rx <= {rx[6:0], sda_w};
            end else if (nb >= 2 && is_rd && matched) begin
                if (nmack < 4) mack[nmack] <= sda_w;
                nmack     <= nmack + 1;
                last_mack <= sda_w;
            end
            bitn <= bitn + 1;
        end else if (active && !scl_w && scl_prev) begin
            if (bitn >= 1 && bitn <= 7) begin
                if (is_rd && matched && nb >= 1) begin
                    rd_sh   <= {rd_sh[30:0], 1'b0};
                    slv_low <= ~rd_sh[30];
                end
            end else if (bitn == 8) begin
                if (nb < 8) log_b[nb] <= rx;
                nb <= nb + 1;
                if (nb == 0) begin
                    is_rd   <= rx[0];
                    matched <= (rx[7:1] == SLV_ADDR);
                    slv_low <= (rx[7:1] == SLV_ADDR);
                end else if (is_rd) begin
                    rd_sh   <= {rd_sh[30:0], 1'b0};
                    slv_low <= 1'b0;
                end else begin
                    slv_low <= (nb != nack_at);
                end
            end else if (bitn == 9) begin
                bitn <= 0;
                if (is_rd && matched && nb == 1) begin
                    rd_sh   <= rd_word;
                    slv_low <= ~rd_word[31];
                end else if (is_rd && matched && !last_mack) begin
                    slv_low <= ~rd_sh[31];
                end else begin
                    slv_low <= 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_txn(input logic t_rw, input logic t_sel, input logic [6:0] t_addr,
                          input logic [31:0] t_wd, output int ncyc, output int acc_cyc);
        @(posedge clk); #1;
        start = 1'b1; rw = t_rw; addr_sel = t_sel; addr = t_addr; wdata = t_wd;
        @(posedge clk); #1;
        start = 1'b0;
        acc_cyc = cyc;
        ncyc = 0;
        while (done !== 1'b1 && ncyc < MAX_WAIT) begin
            @(posedge clk); #1;
            ncyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_w); end
        checks++; if (scl_w !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl_w); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_read;
        int d0;
        rd_word = 32'h12345678;
        nack_at = 99;
        @(posedge clk); #1;
        start = 1'b1; rw = 1'b1; addr_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        // 470 clocks after accept lands inside data byte 3 (bit times 28..36).
        repeat (470) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (scl_w !== 1'b1) begin errors++; $display("FAIL midrst_scl: got %b want 1", scl_w); end
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL midrst_sda: got %b want 1", sda_w); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
        checks++; if (scl_w !== 1'b1) begin errors++; $display("FAIL midrst_scl_idle: got %b want 1", scl_w); end
    endtask

    task automatic test_write;
        int n, acc, s0, p0, d0;
        nack_at = 99;
        s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        do_txn(1'b0, 1'b0, 7'h00, 32'hCCAAF0F0, n, acc);
        checks++; if (n != FULL_CYC) begin errors++; $display("FAIL wr_latency: got %0d want %0d", n, FULL_CYC); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err: got %b want 0", ack_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_width: got %b want 0", done); end
        checks++; if (nb != 5) begin errors++; $display("FAIL wr_nbytes: got %0d want 5", nb); end
        checks++;
        if ({log_b[0], log_b[1], log_b[2], log_b[3], log_b[4]} !== 40'h54CCAAF0F0) begin
            errors++;
            $display("FAIL wr_bus_bytes: got %h want 54ccaaf0f0", {log_b[0], log_b[1], log_b[2], log_b[3], log_b[4]});
        end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL wr_start_cnt: got %0d want 1", start_cnt - s0); end
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL wr_stop_cnt: got %0d want 1", stop_cnt - p0); end
        checks++;
        if (start_cyc - acc < 2 * CLK_DIV || start_cyc - acc > 2 * CLK_DIV + 2) begin
            errors++;
            $display("FAIL wr_start_delay: got %0d want %0d..%0d", start_cyc - acc, 2 * CLK_DIV, 2 * CLK_DIV + 2);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_read;
        int n, acc;
        rd_word = 32'hA5A55A5A;
        nack_at = 99;
        do_txn(1'b1, 1'b0, 7'h00, 32'h0, n, acc);
        checks++; if (n != FULL_CYC) begin errors++; $display("FAIL rd_latency: got %0d want %0d", n, FULL_CYC); end
        checks++; if (rdata !== 32'hA5A55A5A) begin errors++; $display("FAIL rd_rdata: got %h want a5a55a5a", rdata); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err: got %b want 0", ack_err); end
        @(posedge clk); #1;
        checks++; if (log_b[0] !== 8'h55) begin errors++; $display("FAIL rd_addr_byte: got %h want 55", log_b[0]); end
        checks++;
        if ({mack[0], mack[1], mack[2], mack[3]} !== 4'b0001) begin
            errors++;
            $display("FAIL rd_master_acks: got %b want 0001", {mack[0], mack[1], mack[2], mack[3]});
        end
        checks++; if (nmack != 4) begin errors++; $display("FAIL rd_ack_count: got %0d want 4", nmack); end
    endtask

    task automatic test_addr_nack;
        int n, acc, p0;
        nack_at = 99;
        p0 = stop_cnt;
        do_txn(1'b0, 1'b1, 7'h11, 32'hDEADBEEF, n, acc);
        checks++; if (n != NACK_CYC) begin errors++; $display("FAIL an_latency: got %0d want %0d", n, NACK_CYC); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL an_ack_err: got %b want 1", ack_err); end
        checks++; if (rdata !== 32'hA5A55A5A) begin errors++; $display("FAIL an_rdata_kept: got %h want a5a55a5a", rdata); end
        @(posedge clk); #1;
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL an_stop: got %0d want 1", stop_cnt - p0); end
        checks++; if (nb != 1 || log_b[0] !== 8'h22) begin errors++; $display("FAIL an_bus: got %0d bytes first %h want 1 byte 22", nb, log_b[0]); end
    endtask

    task automatic test_wdata_nack;
        int n, acc, p0;
        nack_at = 2;
        p0 = stop_cnt;
        do_txn(1'b0, 1'b0, 7'h00, 32'h11223344, n, acc);
        checks++; if (n != WN2_CYC) begin errors++; $display("FAIL wn_latency: got %0d want %0d", n, WN2_CYC); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL wn_ack_err: got %b want 1", ack_err); end
        @(posedge clk); #1;
        checks++; if (nb != 3) begin errors++; $display("FAIL wn_nbytes: got %0d want 3", nb); end
        checks++;
        if ({log_b[0], log_b[1], log_b[2]} !== 24'h541122) begin
            errors++;
            $display("FAIL wn_bus_bytes: got %h want 541122", {log_b[0], log_b[1], log_b[2]});
        end
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL wn_stop: got %0d want 1", stop_cnt - p0); end
        nack_at = 99;
    endtask

    task automatic test_back_to_back;
        int d0, acc, acc2, n;
        nack_at = 99;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; rw = 1'b0; addr_sel = 1'b0; wdata = 32'h0F1E2D3C;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_accept: got %b want 1", busy); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL b2b_ack_err_cleared: got %b want 0", ack_err); end
        repeat (100) @(posedge clk);
        #1;
        start = 1'b1; rw = 1'b1; addr_sel = 1'b1; addr = 7'h11;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < MAX_WAIT) begin @(posedge clk); #1; n++; end
        checks++; if (cyc - acc != FULL_CYC) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc - acc, FULL_CYC); end
        // start raised while done is high must be ignored
        start = 1'b1; rw = 1'b0; addr_sel = 1'b0; wdata = 32'h89ABCDEF;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: got busy %b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        acc2 = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy %b want 1", busy); end
        n = 0;
        while (done !== 1'b1 && n < MAX_WAIT) begin @(posedge clk); #1; n++; end
        checks++; if (cyc - acc2 != FULL_CYC) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc - acc2, FULL_CYC); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
        checks++;
        if ({log_b[0], log_b[1], log_b[2], log_b[3], log_b[4]} !== 40'h5489ABCDEF) begin
            errors++;
            $display("FAIL b2b_bus_bytes: got %h want 5489abcdef", {log_b[0], log_b[1], log_b[2], log_b[3], log_b[4]});
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_write();
        test_read();
        test_addr_nack();
        test_wdata_nack();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
